// File: rtl/ddr_par.sv
// Shared definitions for the DDR command-bus decoder: command encodings,
// init-sequence state codes and error codes.
package ddr_par;

    // Command code as seen on {csn, rasn, casn, wen}
    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_LMR = 4'b0000;
    localparam cmd_t CMD_AR  = 4'b0001;
    localparam cmd_t CMD_PRE = 4'b0010;
    localparam cmd_t CMD_ACT = 4'b0011;
    localparam cmd_t CMD_WR  = 4'b0100;
    localparam cmd_t CMD_RD  = 4'b0101;
    localparam cmd_t CMD_BST = 4'b0110;
    localparam cmd_t CMD_NOP = 4'b0111;
    // Any code with csn=1 is an inhibit; this is the idle-bus form
    localparam cmd_t CMD_INH = 4'b1111;

    // Init-sequence states
    localparam logic [2:0] I_WAIT = 3'd0;
    localparam logic [2:0] I_PRE  = 3'd1;
    localparam logic [2:0] I_EMRS = 3'd2;
    localparam logic [2:0] I_MRS  = 3'd3;
    localparam logic [2:0] I_AR1  = 3'd4;
    localparam logic [2:0] I_DONE = 3'd5;

    // Error codes, lower code has higher priority
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_INIT      = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
    localparam logic [2:0] ERR_RW_CLOSED = 3'd3;
    localparam logic [2:0] ERR_RCD       = 3'd4;
    localparam logic [2:0] ERR_RP        = 3'd5;
    localparam logic [2:0] ERR_AR_OPEN   = 3'd6;
    localparam logic [2:0] ERR_MRD       = 3'd7;

    // Width of the tRCD/tRP/tMRD down-counters
    localparam int CNT_W = 4;

endpackage

// File: rtl/ddr_bank_trk.sv
// Per-bank state for the DDR command decoder: open flag, open row and the
// ACTIVE->READ/WRITE and PRECHARGE->ACTIVE guard counters.
module ddr_bank_trk
    import ddr_par::*;
#(
    parameter int DDR_A_WIDTH = 12,
    parameter int T_RCD       = 3,
    parameter int T_RP        = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   act,
    input  logic                   close,
    input  logic [DDR_A_WIDTH-1:0] row,
    output logic                   open_flag,
    output logic [DDR_A_WIDTH-1:0] open_row,
    output logic                   rcd_busy,
    output logic                   rp_busy
);

    logic [CNT_W-1:0] rcd_cnt;
    logic [CNT_W-1:0] rp_cnt;

    // Open flag and row follow ACTIVE / any form of precharge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_flag <= 1'b0;
            open_row  <= '0;
        end else if (act) begin
            open_flag <= 1'b1;
            open_row  <= row;
        end else if (close) begin
            open_flag <= 1'b0;
        end
    end

    // Guard counters load on the command edge and count down to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcd_cnt <= '0;
            rp_cnt  <= '0;
        end else begin
            if (act)
                rcd_cnt <= CNT_W'(T_RCD - 1);
            else if (rcd_cnt != '0)
                rcd_cnt <= rcd_cnt - CNT_W'(1);
            if (close)
                rp_cnt <= CNT_W'(T_RP - 1);
            else if (rp_cnt != '0)
                rp_cnt <= rp_cnt - CNT_W'(1);
        end
    end

    assign rcd_busy = (rcd_cnt != '0);
    assign rp_busy  = (rp_cnt != '0);

endmodule

// File: rtl/ddr_cmd_decoder.sv
// Passive DDR command-bus monitor: decodes commands, captures mode registers,
// follows the init sequence, tracks open rows and flags protocol violations.
module ddr_cmd_decoder
    import ddr_par::*;
#(
    parameter int DDR_BA_WIDTH = 2,
    parameter int DDR_A_WIDTH  = 12,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 3,
    parameter int T_MRD        = 2,
    parameter int NB           = 2**DDR_BA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ddr_cke,
    input  logic                      ddr_csn,
    input  logic                      ddr_rasn,
    input  logic                      ddr_casn,
    input  logic                      ddr_wen,
    input  logic [DDR_BA_WIDTH-1:0]   ddr_ba,
    input  logic [DDR_A_WIDTH-1:0]    ddr_add,
    output logic                      cmd_valid,
    output logic [3:0]                cmd_code,
    output logic [DDR_BA_WIDTH-1:0]   cmd_ba,
    output logic [DDR_A_WIDTH-1:0]    cmd_addr,
    output logic [2:0]                mr_cl,
    output logic [2:0]                mr_bl,
    output logic                      mr_bt,
    output logic                      emr_dll,
    output logic                      emr_ds,
    output logic                      init_done,
    output logic [NB-1:0]             bank_open,
    output logic [NB*DDR_A_WIDTH-1:0] open_row,
    output logic                      err_valid,
    output logic [2:0]                err_code
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] mrd_cnt;
    logic [NB-1:0]    rcd_busy;
    logic [NB-1:0]    rp_busy;

    // ---- stage p0: command on the pins, decoded combinationally ----
    cmd_t          code_p0;
    logic          vld_p0;
    logic          a10_p0;
    logic          done_p0;
    logic          is_act_p0, is_rw_p0, is_pre_p0, is_ar_p0, is_lmr_p0;
    logic          ba_mr_p0, ba_emr_p0;
    logic          init_ok_p0, mr_wr_p0, emr_wr_p0;
    logic [2:0]    err_p0;
    logic [NB-1:0] act_p0, close_p0;

    assign code_p0   = {ddr_csn, ddr_rasn, ddr_casn, ddr_wen};
    assign vld_p0    = ddr_cke && !ddr_csn && (code_p0 != CMD_NOP);
    assign a10_p0    = ddr_add[10];
    assign done_p0   = (state == I_DONE);
    assign is_act_p0 = vld_p0 && (code_p0 == CMD_ACT);
    assign is_rw_p0  = vld_p0 && ((code_p0 == CMD_RD) || (code_p0 == CMD_WR));
    assign is_pre_p0 = vld_p0 && (code_p0 == CMD_PRE);
    assign is_ar_p0  = vld_p0 && (code_p0 == CMD_AR);
    assign is_lmr_p0 = vld_p0 && (code_p0 == CMD_LMR);
    assign ba_mr_p0  = (ddr_ba == '0);
    assign ba_emr_p0 = (ddr_ba == DDR_BA_WIDTH'(1));

    // Init sequence: next state, legality and which mode register to capture
    always_comb begin
        state_nxt  = state;
        init_ok_p0 = 1'b1;
        mr_wr_p0   = 1'b0;
        emr_wr_p0  = 1'b0;
        if (vld_p0) begin
            case (state)
                I_WAIT: if (is_pre_p0 && a10_p0) state_nxt = I_PRE;
                        else init_ok_p0 = 1'b0;
                I_PRE:  if (is_lmr_p0 && ba_emr_p0) begin
                            state_nxt = I_EMRS;
                            emr_wr_p0 = 1'b1;
                        end else init_ok_p0 = 1'b0;
                I_EMRS: if (is_lmr_p0 && ba_mr_p0) begin
                            state_nxt = I_MRS;
                            mr_wr_p0  = 1'b1;
                        end else init_ok_p0 = 1'b0;
                I_MRS:  if (is_lmr_p0 && ba_mr_p0) mr_wr_p0 = 1'b1;
                        else if (is_ar_p0) state_nxt = I_AR1;
                        else init_ok_p0 = 1'b0;
                I_AR1:  if (is_lmr_p0 && ba_mr_p0) mr_wr_p0 = 1'b1;
                        else if (is_ar_p0) state_nxt = I_DONE;
                        else init_ok_p0 = 1'b0;
                I_DONE: begin
                    mr_wr_p0  = is_lmr_p0 && ba_mr_p0;
                    emr_wr_p0 = is_lmr_p0 && ba_emr_p0;
                end
                default: state_nxt = I_WAIT;
            endcase
        end
    end

    // Error priority: checks use bank/counter state from before this command
    always_comb begin
        err_p0 = ERR_NONE;
        if (vld_p0) begin
            if (!init_ok_p0)
                err_p0 = ERR_INIT;
            else if (done_p0 && is_act_p0 && bank_open[ddr_ba])
                err_p0 = ERR_ACT_OPEN;
            else if (done_p0 && is_rw_p0 && !bank_open[ddr_ba])
                err_p0 = ERR_RW_CLOSED;
            else if (done_p0 && is_rw_p0 && rcd_busy[ddr_ba])
                err_p0 = ERR_RCD;
            else if (done_p0 && ((is_act_p0 && rp_busy[ddr_ba]) || (is_ar_p0 && (|rp_busy))))
                err_p0 = ERR_RP;
            else if (done_p0 && is_ar_p0 && (|bank_open))
                err_p0 = ERR_AR_OPEN;
            else if (mrd_cnt != '0)
                err_p0 = ERR_MRD;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_bank
        assign act_p0[i]   = done_p0 && is_act_p0 && (ddr_ba == DDR_BA_WIDTH'(i));
        assign close_p0[i] = done_p0 &&
                             ((is_rw_p0 && a10_p0 && (ddr_ba == DDR_BA_WIDTH'(i))) ||
                              (is_pre_p0 && (a10_p0 || (ddr_ba == DDR_BA_WIDTH'(i)))));

        ddr_bank_trk #(
            .DDR_A_WIDTH (DDR_A_WIDTH),
            .T_RCD       (T_RCD),
            .T_RP        (T_RP)
        ) u_trk (
            .clk       (clk),
            .reset_n   (reset_n),
            .act       (act_p0[i]),
            .close     (close_p0[i]),
            .row       (ddr_add),
            .open_flag (bank_open[i]),
            .open_row  (open_row[i*DDR_A_WIDTH +: DDR_A_WIDTH]),
            .rcd_busy  (rcd_busy[i]),
            .rp_busy   (rp_busy[i])
        );
    end

    // ---- stage p1: registered outputs ----

    // Init state, mode-register capture and the LMR guard counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= I_WAIT;
            mr_cl   <= '0;
            mr_bl   <= '0;
            mr_bt   <= 1'b0;
            emr_dll <= 1'b0;
            emr_ds  <= 1'b0;
            mrd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (mr_wr_p0) begin
                mr_cl <= ddr_add[6:4];
                mr_bt <= ddr_add[3];
                mr_bl <= ddr_add[2:0];
            end
            if (emr_wr_p0) begin
                emr_dll <= ddr_add[0];
                emr_ds  <= ddr_add[1];
            end
            if (is_lmr_p0)
                mrd_cnt <= CNT_W'(T_MRD - 1);
            else if (mrd_cnt != '0)
                mrd_cnt <= mrd_cnt - CNT_W'(1);
        end
    end

    // Decoded-command and error reporting registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            cmd_valid <= vld_p0;
            if (vld_p0) begin
                cmd_code <= code_p0;
                cmd_ba   <= ddr_ba;
                cmd_addr <= ddr_add;
            end
            err_valid <= (err_p0 != ERR_NONE);
            err_code  <= err_p0;
        end
    end

    assign init_done = (state == I_DONE);

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed bench for ddr_cmd_decoder with a timestamp-based reference model.
module tb_ddr_cmd_decoder;

    localparam int AW = 12;
    localparam int NB = 4;
    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_MRD = 2;

    localparam logic [3:0] C_LMR = 4'b0000, C_AR = 4'b0001, C_PRE = 4'b0010,
                           C_ACT = 4'b0011, C_WR = 4'b0100, C_RD  = 4'b0101,
                           C_BST = 4'b0110, C_NOP = 4'b0111, C_INH = 4'b1011;

    logic          clk, reset_n;
    logic          ddr_cke, ddr_csn, ddr_rasn, ddr_casn, ddr_wen;
    logic [1:0]    ddr_ba;
    logic [AW-1:0] ddr_add;
    logic          cmd_valid;
    logic [3:0]    cmd_code;
    logic [1:0]    cmd_ba;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    mr_cl, mr_bl;
    logic          mr_bt, emr_dll, emr_ds, init_done;
    logic [NB-1:0] bank_open;
    logic [NB*AW-1:0] open_row;
    logic          err_valid;
    logic [2:0]    err_code;

    ddr_cmd_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .ddr_cke(ddr_cke), .ddr_csn(ddr_csn), .ddr_rasn(ddr_rasn),
        .ddr_casn(ddr_casn), .ddr_wen(ddr_wen), .ddr_ba(ddr_ba), .ddr_add(ddr_add),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .mr_cl(mr_cl), .mr_bl(mr_bl), .mr_bt(mr_bt), .emr_dll(emr_dll), .emr_ds(emr_ds),
        .init_done(init_done), .bank_open(bank_open), .open_row(open_row),
        .err_valid(err_valid), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            cyc;
    int            step;           // 0..5 = how far the init sequence has progressed
    bit            m_open [NB];
    logic [AW-1:0] m_row  [NB];
    int            t_act  [NB];
    int            t_close[NB];
    int            t_lmr;
    logic          e_cmd_valid, e_bt, e_dll, e_ds, e_err_valid;
    logic [3:0]    e_code;
    logic [1:0]    e_ba;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_cl, e_bl, e_err_code;

    task automatic model_reset();
        cyc = 0; step = 0; t_lmr = -100;
        for (int k = 0; k < NB; k++) begin
            m_open[k] = 0; m_row[k] = '0; t_act[k] = -100; t_close[k] = -100;
        end
        e_cmd_valid = 0; e_code = 0; e_ba = 0; e_addr = 0;
        e_cl = 0; e_bl = 0; e_bt = 0; e_dll = 0; e_ds = 0;
        e_err_valid = 0; e_err_code = 0;
    endtask

    task automatic model_step();
        logic [3:0] c;
        int b, e;
        bit a10, legal, done, rw, anyopen, anyrp;
        cyc++;
        e_cmd_valid = 0; e_err_valid = 0; e_err_code = 0;
        c = {ddr_csn, ddr_rasn, ddr_casn, ddr_wen};
        b = int'(ddr_ba);
        a10 = ddr_add[10];
        if (!ddr_cke || ddr_csn || c == C_NOP) return;
        e_cmd_valid = 1; e_code = c; e_ba = ddr_ba; e_addr = ddr_add;
        done = (step == 5);
        rw = (c == C_RD) || (c == C_WR);
        legal = 1;
        case (step)
            0: if (c == C_PRE && a10) step = 1; else legal = 0;
            1: if (c == C_LMR && b == 1) begin
                   step = 2; e_dll = ddr_add[0]; e_ds = ddr_add[1];
               end else legal = 0;
            2, 3, 4: if (c == C_LMR && b == 0) begin
                   e_cl = ddr_add[6:4]; e_bt = ddr_add[3]; e_bl = ddr_add[2:0];
                   if (step == 2) step = 3;
               end else if (c == C_AR && step >= 3) step++;
               else legal = 0;
            default: begin
                if (c == C_LMR && b == 0) begin
                    e_cl = ddr_add[6:4]; e_bt = ddr_add[3]; e_bl = ddr_add[2:0];
                end
                if (c == C_LMR && b == 1) begin
                    e_dll = ddr_add[0]; e_ds = ddr_add[1];
                end
            end
        endcase
        anyopen = 0; anyrp = 0;
        for (int k = 0; k < NB; k++) begin
            if (m_open[k]) anyopen = 1;
            if (cyc - t_close[k] < T_RP) anyrp = 1;
        end
        e = 0;
        if (!legal) e = 1;
        else if (done && c == C_ACT && m_open[b]) e = 2;
        else if (done && rw && !m_open[b]) e = 3;
        else if (done && rw && (cyc - t_act[b] < T_RCD)) e = 4;
        else if (done && ((c == C_ACT && (cyc - t_close[b] < T_RP)) || (c == C_AR && anyrp))) e = 5;
        else if (done && c == C_AR && anyopen) e = 6;
        else if (cyc - t_lmr < T_MRD) e = 7;
        e_err_valid = (e != 0);
        e_err_code = 3'(e);
        if (c == C_LMR) t_lmr = cyc;
        if (done) begin
            if (c == C_ACT) begin
                m_open[b] = 1; m_row[b] = ddr_add; t_act[b] = cyc;
            end
            if (rw && a10) begin
                m_open[b] = 0; t_close[b] = cyc;
            end
            if (c == C_PRE)
                for (int k = 0; k < NB; k++)
                    if (a10 || k == b) begin
                        m_open[k] = 0; t_close[k] = cyc;
                    end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle, on the falling edge
    initial begin
        logic [NB-1:0]    eo;
        logic [NB*AW-1:0] er;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NB; k++) begin
                eo[k] = m_open[k];
                er[k*AW +: AW] = m_row[k];
            end
            chk("cmd_valid", cmd_valid, e_cmd_valid);
            chk("cmd_code", cmd_code, e_code);
            chk("cmd_ba", cmd_ba, e_ba);
            chk("cmd_addr", cmd_addr, e_addr);
            chk("mr", {mr_cl, mr_bt, mr_bl}, {e_cl, e_bt, e_bl});
            chk("emr", {emr_dll, emr_ds}, {e_dll, e_ds});
            chk("init_done", init_done, step == 5);
            chk("bank_open", bank_open, eo);
            chk("open_row", open_row, er);
            chk("err", {err_valid, err_code}, {e_err_valid, e_err_code});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] c, input int b, input int a, input bit cke);
        {ddr_csn, ddr_rasn, ddr_casn, ddr_wen} = c;
        ddr_ba = b[1:0];
        ddr_add = a[AW-1:0];
        ddr_cke = cke;
    endtask

    task automatic issue(input logic [3:0] c, input int b, input int a, input bit cke = 1'b1);
        @(negedge clk);
        drive(c, b, a, cke);
        @(posedge clk);
        #1;
        drive(C_NOP, 0, 0, 1'b1);
    endtask

    task automatic nop(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic init_seq();
        issue(C_PRE, 0, 12'h400); nop(1);
        issue(C_LMR, 1, 12'h002); nop(1);
        issue(C_LMR, 0, 12'h032); nop(1);
        issue(C_AR, 0, 0);
        issue(C_AR, 0, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        drive(C_NOP, 0, 0, 1'b1);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_init_done", init_done, 0);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        reset_n = 1'b1;

        // Init with an MRS issued before the EMRS
        issue(C_PRE, 0, 12'h400);
        chk("pre_code", cmd_code, 4'h2);
        nop(1);
        issue(C_LMR, 0, 12'h032);
        chk("early_mrs_err", {err_valid, err_code}, {1'b1, 3'd1});
        nop(1);
        issue(C_LMR, 1, 12'h002);
        chk("emrs_after_bad_err", err_valid, 0);
        nop(1);
        issue(C_LMR, 0, 12'h032);
        issue(C_AR, 0, 0);
        issue(C_AR, 0, 0);
        chk("init1_done", init_done, 1);

        // Bank tracking and timing
        issue(C_ACT, 1, 12'h155);
        chk("act1_open", bank_open, 4'b0010);
        nop(2);
        issue(C_RD, 1, 12'h010);
        chk("rd1_err", err_valid, 0);
        chk("open_row1", open_row[23:12], 12'h155);
        issue(C_ACT, 0, 12'h0AA); nop(1);
        issue(C_RD, 0, 12'h020);
        chk("rcd_err", err_code, 3'd4);
        issue(C_ACT, 2, 12'h033); nop(2);
        issue(C_RD, 2, 12'h400);
        chk("autopre_open", bank_open, 4'b0011);
        issue(C_ACT, 2, 12'h044);
        chk("rp_err", err_code, 3'd5);
        nop(2);
        issue(C_RD, 2, 12'h400); nop(2);
        issue(C_ACT, 2, 12'h066);
        chk("rp_ok", err_valid, 0);
        chk("open_row2", open_row[35:24], 12'h066);
        issue(C_ACT, 0, 12'h0BB);
        chk("act_open_err", err_code, 3'd2);
        issue(C_RD, 3, 12'h010);
        chk("rd_closed_err", err_code, 3'd3);
        issue(C_AR, 0, 0);
        chk("ar_open_err", err_code, 3'd6);
        issue(C_WR, 1, 12'h400);
        issue(C_PRE, 0, 12'h400);
        chk("pre_all_open", bank_open, 4'b0000);
        issue(C_AR, 0, 0);
        chk("ar_rp_err", err_code, 3'd5);
        nop(2);
        issue(C_AR, 0, 0);
        chk("ar_ok", err_valid, 0);
        issue(C_LMR, 0, 12'h022);
        chk("mrs_cl2", mr_cl, 3'd2);
        issue(C_ACT, 0, 12'h011);
        chk("mrd_err", err_code, 3'd7);
        nop(1);
        issue(C_LMR, 1, 12'h001);
        chk("emr_dll", {emr_dll, emr_ds}, 2'b10);
        nop(1);
        issue(C_BST, 0, 0);
        chk("bst_code", cmd_code, 4'h6);
        issue(C_ACT, 1, 12'h0FF, 1'b0);
        chk("cke0_ignored", cmd_valid, 0);
        issue(C_INH, 1, 12'h0FF);
        chk("inhibit_ignored", cmd_valid, 0);

        // Asynchronous reset with banks open and an error pending
        issue(C_ACT, 3, 12'h0CC);
        issue(C_RD, 3, 12'h010);
        chk("pre_rst_err", err_valid, 1);
        chk("pre_rst_open", bank_open, 4'b1001);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_init_done", init_done, 0);
        chk("arst_bank_open", bank_open, 0);
        chk("arst_err_valid", err_valid, 0);
        chk("arst_open_row", open_row, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Clean init
        init_seq();
        chk("init2_done", init_done, 1);
        chk("init2_mr", {mr_cl, mr_bl}, {3'd3, 3'd2});
        chk("init2_emr_ds", emr_ds, 1);
        chk("init2_err", err_valid, 0);

        // Reset in the middle of init
        do_reset();
        issue(C_PRE, 0, 12'h400); nop(1);
        issue(C_LMR, 1, 12'h002);
        #2 reset_n = 1'b0;
        #1;
        chk("midinit_done", init_done, 0);
        chk("midinit_emr", emr_ds, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        nop(1);
        issue(C_AR, 0, 0);
        chk("after_rst_ar_err", err_code, 3'd1);
        nop(2);

        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
